// File: rtl/ir_pkg.sv
// Shared NEC/IR definitions: event encodings, controller states, frame fields.
// The frame receiver can reuse the field indices and the validity check.
package ir_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_HOLD    = 2'd1,
        EVT_RELEASE = 2'd2
    } evt_type_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam int ADDR_MSB  = 31;
    localparam int ADDR_LSB  = 24;
    localparam int ADDRN_MSB = 23;
    localparam int ADDRN_LSB = 16;
    localparam int CMD_MSB   = 15;
    localparam int CMD_LSB   = 8;
    localparam int CMDN_MSB  = 7;
    localparam int CMDN_LSB  = 0;

    localparam int EVT_W = 10;

    function automatic logic frame_ok(
        input logic [31:0] f,
        input logic        filt,
        input logic [7:0]  addr
    );
        logic [7:0] a;
        logic [7:0] an;
        logic [7:0] c;
        logic [7:0] cn;
        a  = f[ADDR_MSB:ADDR_LSB];
        an = f[ADDRN_MSB:ADDRN_LSB];
        c  = f[CMD_MSB:CMD_LSB];
        cn = f[CMDN_MSB:CMDN_LSB];
        return (a == ~an) && (c == ~cn) && (!filt || (a == addr));
    endfunction

endpackage

// File: rtl/ir_evt_fifo.sv
// Synchronous event FIFO, power-of-2 depth, valid/ready pop.
// A push while full is only taken when a pop frees a slot the same cycle.
module ir_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          pop;
    logic          wr;

    assign pop_valid = count != '0;
    assign full      = count == (AW+1)'(DEPTH);
    assign pop       = pop_valid && pop_ready;
    assign wr        = push && (!full || pop);
    assign pop_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ir_key_ctrl.sv
// NEC key-event controller: validates frames, tracks the held key and
// emits PRESS/HOLD/RELEASE events into a small FIFO.
module ir_key_ctrl
    import ir_pkg::*;
#(
    parameter int         CLK_HZ         = 50_000_000,
    parameter int         RELEASE_MS     = 120,
    parameter int         HOLD_REPEATS   = 5,
    parameter int         HOLD_EVERY     = 2,
    parameter bit         ADDR_FILTER_EN = 1'b0,
    parameter logic [7:0] ADDR           = 8'h00,
    parameter int         FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_en,
    input  logic [31:0] frame_data,
    input  logic        repeat_en,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [1:0]  evt_type,
    output logic [7:0]  evt_key,
    output logic        held,
    output logic [7:0]  held_key,
    output logic [7:0]  err_cnt,
    output logic [7:0]  drop_cnt
);
    localparam int PRESC = CLK_HZ / 1000;
    localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int MW    = $clog2(RELEASE_MS + 1);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  key_q;
    logic [7:0]  key_nx;
    logic [7:0]  new_q;
    logic [7:0]  new_nx;
    logic [7:0]  rep_q;
    logic [7:0]  rep_nx;
    logic [7:0]  rep_inc;
    logic [7:0]  div_q;
    logic [7:0]  div_nx;
    logic [PW-1:0] presc;
    logic [MW-1:0] ms_cnt;

    logic        good;
    logic        bad;
    logic [7:0]  cmd;
    logic        timeout;
    logic        tmr_clr;
    logic        push;
    evt_type_t   push_type;
    logic [7:0]  push_key;
    logic        fifo_full;
    logic        accept;
    logic [EVT_W-1:0] head;

    assign good    = frame_ok(frame_data, ADDR_FILTER_EN, ADDR);
    assign bad     = frame_en && !good;
    assign cmd     = frame_data[CMD_MSB:CMD_LSB];
    assign timeout = ms_cnt == MW'(RELEASE_MS);
    assign rep_inc = (rep_q == 8'hFF) ? rep_q : rep_q + 8'd1;

    always_comb begin
        state_nx  = state;
        key_nx    = key_q;
        new_nx    = new_q;
        rep_nx    = rep_q;
        div_nx    = div_q;
        tmr_clr   = 1'b0;
        push      = 1'b0;
        push_type = EVT_PRESS;
        push_key  = key_q;
        unique case (state)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (frame_en && good) begin
                    push     = 1'b1;
                    push_key = cmd;
                    key_nx   = cmd;
                    rep_nx   = '0;
                    div_nx   = '0;
                    state_nx = ST_HELD;
                end
            end
            ST_HELD: begin
                if (frame_en && good && cmd != key_q) begin
                    push      = 1'b1;
                    push_type = EVT_RELEASE;
                    new_nx    = cmd;
                    state_nx  = ST_SWITCH;
                end else if ((frame_en && good) || repeat_en) begin
                    // Same-key frame counts as a repeat of the held key
                    tmr_clr = 1'b1;
                    rep_nx  = rep_inc;
                    if (rep_q != 8'hFF && rep_inc == 8'(HOLD_REPEATS)) begin
                        push      = 1'b1;
                        push_type = EVT_HOLD;
                        div_nx    = '0;
                    end else if (rep_inc > 8'(HOLD_REPEATS)) begin
                        if (div_q + 8'd1 == 8'(HOLD_EVERY)) begin
                            push      = 1'b1;
                            push_type = EVT_HOLD;
                            div_nx    = '0;
                        end else begin
                            div_nx = div_q + 8'd1;
                        end
                    end
                end else if (timeout) begin
                    push      = 1'b1;
                    push_type = EVT_RELEASE;
                    key_nx    = '0;
                    state_nx  = ST_IDLE;
                end
            end
            ST_SWITCH: begin
                push     = 1'b1;
                push_key = new_q;
                key_nx   = new_q;
                rep_nx   = '0;
                div_nx   = '0;
                tmr_clr  = 1'b1;
                state_nx = ST_HELD;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            key_q <= '0;
            new_q <= '0;
            rep_q <= '0;
            div_q <= '0;
        end else begin
            state <= state_nx;
            key_q <= key_nx;
            new_q <= new_nx;
            rep_q <= rep_nx;
            div_q <= div_nx;
        end
    end

    // ms counter saturates at RELEASE_MS; only meaningful while HELD
    always_ff @(posedge clk) begin
        if (rst || tmr_clr) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (presc == PW'(PRESC - 1)) begin
            presc <= '0;
            if (!timeout)
                ms_cnt <= ms_cnt + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (bad && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (push && !accept && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign accept = !fifo_full || (evt_valid && evt_ready);

    ir_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({push_type, push_key}),
        .full      (fifo_full),
        .pop_valid (evt_valid),
        .pop_ready (evt_ready),
        .pop_data  (head)
    );

    assign evt_type = head[9:8];
    assign evt_key  = head[7:0];
    assign held     = state != ST_IDLE;
    assign held_key = key_q;

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Self-checking bench for ir_key_ctrl; clock scaled to 20 kHz (20 cycles/ms)
// so the 120 ms release windows stay short.
module tb_ir_key_ctrl;

    localparam int MS  = 20;
    localparam int REL = 120 * MS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_en = 1'b0;
    logic [31:0] frame_data = '0;
    logic        repeat_en = 1'b0;
    logic        evt_valid;
    logic        evt_ready = 1'b1;
    logic [1:0]  evt_type;
    logic [7:0]  evt_key;
    logic        held;
    logic [7:0]  held_key;
    logic [7:0]  err_cnt;
    logic [7:0]  drop_cnt;

    ir_key_ctrl #(.CLK_HZ(20_000)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_en   (frame_en),
        .frame_data (frame_data),
        .repeat_en  (repeat_en),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_type   (evt_type),
        .evt_key    (evt_key),
        .held       (held),
        .held_key   (held_key),
        .err_cnt    (err_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] t;
        logic [7:0] k;
        int         c;
    } ev_t;

    typedef struct {
        logic [31:0] data;
        bit          ok;
        logic [7:0]  key;
    } vec_t;

    ev_t  log_q[$];
    vec_t vecs[7];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (!rst && evt_valid && evt_ready)
            log_q.push_back('{evt_type, evt_key, cyc});

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] d, output int st);
        @(negedge clk);
        frame_data = d;
        frame_en   = 1'b1;
        st         = cyc;
        @(negedge clk);
        frame_en   = 1'b0;
    endtask

    task automatic send_repeat(output int st);
        @(negedge clk);
        repeat_en = 1'b1;
        st        = cyc;
        @(negedge clk);
        repeat_en = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, (log_q.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic chk_ev(input string name, input int i,
                          input int t, input int k);
        if (i < log_q.size()) begin
            chk({name, ".type"}, int'(log_q[i].t), t);
            chk({name, ".key"}, int'(log_q[i].k), k);
        end else begin
            chk({name, ".present"}, 0, 1);
        end
    endtask

    function automatic int at(input int i);
        return (i < log_q.size()) ? log_q[i].c : -1;
    endfunction

    function automatic int in_rng(input int v, input int lo, input int hi);
        return (v >= lo && v <= hi) ? 1 : 0;
    endfunction

    initial begin
        int s;
        int g;
        int r[8];
        int k;

        vecs[0] = '{32'h00FF45BA, 1'b1, 8'h45};
        vecs[1] = '{32'h00FF45BB, 1'b0, 8'h00};
        vecs[2] = '{32'h01FF45BA, 1'b0, 8'h00};
        vecs[3] = '{32'h00FF46B9, 1'b1, 8'h46};
        vecs[4] = '{32'h807F10EF, 1'b1, 8'h10};
        vecs[5] = '{32'hFF00FF00, 1'b1, 8'hFF};
        vecs[6] = '{32'h00000000, 1'b0, 8'h00};

        idle(2);
        rst = 1'b0;
        chk("rst.valid", int'(evt_valid), 0);
        chk("rst.held", int'(held), 0);
        chk("rst.held_key", int'(held_key), 0);
        chk("rst.err", int'(err_cnt), 0);
        chk("rst.drop", int'(drop_cnt), 0);
        chk("rst.type", int'(evt_type), 0);

        // Frame validation table, one frame from IDLE each
        evt_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            do_reset();
            send_frame(vecs[i].data, s);
            chk($sformatf("vec%0d.valid", i), int'(evt_valid), int'(vecs[i].ok));
            chk($sformatf("vec%0d.held", i), int'(held), int'(vecs[i].ok));
            chk($sformatf("vec%0d.held_key", i), int'(held_key), int'(vecs[i].key));
            chk($sformatf("vec%0d.err", i), int'(err_cnt), vecs[i].ok ? 0 : 1);
            if (vecs[i].ok) begin
                chk($sformatf("vec%0d.type", i), int'(evt_type), 0);
                chk($sformatf("vec%0d.key", i), int'(evt_key), int'(vecs[i].key));
            end
        end

        // 1: press then silence
        evt_ready = 1'b1;
        do_reset();
        log_q.delete();
        send_frame(32'h00FF45BA, s);
        chk("t1.held", int'(held), 1);
        chk("t1.held_key", int'(held_key), 8'h45);
        wait_log(1, 10, "t1.press_seen");
        chk_ev("t1.press", 0, 0, 8'h45);
        chk("t1.press_lat", at(0) - s, 1);
        wait_log(2, REL + 50, "t1.rel_seen");
        chk_ev("t1.rel", 1, 2, 8'h45);
        chk("t1.rel_time", in_rng(at(1) - s, REL + 1, REL + 2), 1);
        chk("t1.held_after", int'(held), 0);
        chk("t1.held_key_after", int'(held_key), 0);

        // 2: press then 8 repeats 108 ms apart
        do_reset();
        log_q.delete();
        send_frame(32'h00FF45BA, s);
        for (int i = 0; i < 8; i++) begin
            idle(108 * MS - 2);
            send_repeat(r[i]);
        end
        wait_log(4, REL + 50, "t2.seen");
        idle(20);
        chk("t2.count", log_q.size(), 4);
        chk_ev("t2.e0", 0, 0, 8'h45);
        chk_ev("t2.e1", 1, 1, 8'h45);
        chk_ev("t2.e2", 2, 1, 8'h45);
        chk_ev("t2.e3", 3, 2, 8'h45);
        chk("t2.hold5_time", at(1) - r[4], 1);
        chk("t2.hold7_time", at(2) - r[6], 1);
        chk("t2.rel_time", in_rng(at(3) - r[7], REL + 1, REL + 2), 1);

        // 3: invalid frames only
        do_reset();
        log_q.delete();
        send_frame(32'h00FF45BB, s);
        send_frame(32'h01FF45BA, s);
        idle(5);
        chk("t3.events", log_q.size(), 0);
        chk("t3.err", int'(err_cnt), 2);
        chk("t3.held", int'(held), 0);

        // 4: key switch at 50 ms
        do_reset();
        log_q.delete();
        send_frame(32'h00FF45BA, s);
        idle(50 * MS - 2);
        send_frame(32'h00FF46B9, g);
        wait_log(3, 10, "t4.seen");
        chk_ev("t4.rel", 1, 2, 8'h45);
        chk_ev("t4.press", 2, 0, 8'h46);
        chk("t4.rel_time", at(1) - g, 1);
        chk("t4.press_time", at(2) - g, 2);
        chk("t4.held_key", int'(held_key), 8'h46);
        chk("t4.held", int'(held), 1);

        // 5: overflow with consumer stalled
        do_reset();
        log_q.delete();
        evt_ready = 1'b0;
        send_frame(32'h00FF11EE, s);
        idle(3);
        send_frame(32'h00FF22DD, s);
        idle(3);
        send_frame(32'h00FF33CC, s);
        k = 0;
        while (held && k < REL + 50) begin
            @(negedge clk);
            k++;
        end
        chk("t5.released", int'(held), 0);
        idle(3);
        chk("t5.drop", int'(drop_cnt), 2);
        chk("t5.head_valid", int'(evt_valid), 1);
        chk("t5.head_type", int'(evt_type), 0);
        chk("t5.head_key", int'(evt_key), 8'h11);
        evt_ready = 1'b1;
        idle(8);
        chk("t5.count", log_q.size(), 4);
        chk_ev("t5.e0", 0, 0, 8'h11);
        chk_ev("t5.e1", 1, 2, 8'h11);
        chk_ev("t5.e2", 2, 0, 8'h22);
        chk_ev("t5.e3", 3, 2, 8'h22);
        chk("t5.back2back", at(3) - at(0), 3);
        chk("t5.empty", int'(evt_valid), 0);

        // 6: reset while a key is held
        log_q.delete();
        evt_ready = 1'b0;
        send_frame(32'h00FF45BA, s);
        idle(30 * MS);
        chk("t6.pre_held", int'(held), 1);
        do_reset();
        chk("t6.valid", int'(evt_valid), 0);
        chk("t6.held", int'(held), 0);
        chk("t6.held_key", int'(held_key), 0);
        chk("t6.err", int'(err_cnt), 0);
        chk("t6.drop", int'(drop_cnt), 0);
        evt_ready = 1'b1;
        idle(REL + 100);
        chk("t6.no_release", log_q.size(), 0);
        send_frame(32'h00FF45BA, s);
        wait_log(1, 10, "t6.press_seen");
        chk_ev("t6.press", 0, 0, 8'h45);
        chk("t6.press_lat", at(0) - s, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
